// File: rtl/decode_pkg.sv
// Shared definitions for the instruction decode stage.
// - RV32I/RV64I opcode constants.
// - Format enum fmt_e.
// - Skid FSM state enum.
// - decoded_t: one decoded entry. Its pc and imm fields are held at the widest
//   supported XLEN, and each instance of the stage narrows them to its own width.
package decode_pkg;

  localparam int XLEN_MAX = 64;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_LD  = 3'd2,
    FMT_S   = 3'd3,
    FMT_B   = 3'd4,
    FMT_U   = 3'd5,
    FMT_J   = 3'd6,
    FMT_ILL = 3'd7
  } fmt_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_e;

  typedef struct packed {
    logic [XLEN_MAX-1:0] pc;
    logic [4:0]          rd;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic [XLEN_MAX-1:0] imm;
    logic [2:0]          func3;
    logic [6:0]          func7;
    fmt_e                fmt;
    logic                illegal;
  } decoded_t;

endpackage

// File: rtl/decode_comb.sv
// Combinational decoder: instruction word + pc -> decoded_t.
// Ports:
//   instr  in   32        instruction word
//   pc     in   XLEN_MAX  instruction address, zero-extended
//   dec    out  decoded_t decoded fields
// All immediates are sign-extended to XLEN_MAX. Narrowing them to 32 bits gives
// the RV32 value, and the U immediate comes out sign-extended on RV64 as
// required. Every field starts from zero so that no format leaks stale fields.
module decode_comb
  import decode_pkg::*;
(
  input  logic [31:0]         instr,
  input  logic [XLEN_MAX-1:0] pc,
  output decoded_t            dec
);

  function automatic logic signed [XLEN_MAX-1:0] imm_i(input logic [31:0] i);
    return {{(XLEN_MAX-12){i[31]}}, i[31:20]};
  endfunction

  function automatic logic signed [XLEN_MAX-1:0] imm_s(input logic [31:0] i);
    return {{(XLEN_MAX-12){i[31]}}, i[31:25], i[11:7]};
  endfunction

  function automatic logic signed [XLEN_MAX-1:0] imm_b(input logic [31:0] i);
    return {{(XLEN_MAX-13){i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
  endfunction

  function automatic logic signed [XLEN_MAX-1:0] imm_u(input logic [31:0] i);
    return {{(XLEN_MAX-32){i[31]}}, i[31:12], 12'b0};
  endfunction

  function automatic logic signed [XLEN_MAX-1:0] imm_j(input logic [31:0] i);
    return {{(XLEN_MAX-21){i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
  endfunction

  logic [6:0] opcode;
  logic [4:0] f_rd;
  logic [4:0] f_rs1;
  logic [4:0] f_rs2;
  logic [2:0] f_func3;
  logic [6:0] f_func7;

  assign opcode  = instr[6:0];
  assign f_rd    = instr[11:7];
  assign f_rs1   = instr[19:15];
  assign f_rs2   = instr[24:20];
  assign f_func3 = instr[14:12];
  assign f_func7 = instr[31:25];

  always_comb begin
    dec     = '0;
    dec.pc  = pc;
    dec.fmt = FMT_ILL;
    unique case (opcode)
      OP_R: begin
        dec.fmt   = FMT_R;
        dec.rd    = f_rd;
        dec.rs1   = f_rs1;
        dec.rs2   = f_rs2;
        dec.func3 = f_func3;
        dec.func7 = f_func7;
      end
      OP_IMM, OP_JALR: begin
        dec.fmt   = FMT_I;
        dec.rd    = f_rd;
        dec.rs1   = f_rs1;
        dec.func3 = f_func3;
        dec.imm   = imm_i(instr);
      end
      OP_LOAD: begin
        dec.fmt   = FMT_LD;
        dec.rd    = f_rd;
        dec.rs1   = f_rs1;
        dec.func3 = f_func3;
        dec.imm   = imm_i(instr);
      end
      OP_STORE: begin
        dec.fmt   = FMT_S;
        dec.rs1   = f_rs1;
        dec.rs2   = f_rs2;
        dec.func3 = f_func3;
        dec.imm   = imm_s(instr);
      end
      OP_BRANCH: begin
        dec.fmt   = FMT_B;
        dec.rs1   = f_rs1;
        dec.rs2   = f_rs2;
        dec.func3 = f_func3;
        dec.imm   = imm_b(instr);
      end
      OP_LUI, OP_AUIPC: begin
        dec.fmt = FMT_U;
        dec.rd  = f_rd;
        dec.imm = imm_u(instr);
      end
      OP_JAL: begin
        dec.fmt = FMT_J;
        dec.rd  = f_rd;
        dec.imm = imm_j(instr);
      end
      default: begin
        dec.fmt     = FMT_ILL;
        dec.illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// Registered RV32I/RV64I decode stage with a valid/ready handshake on both sides.
// It has an output register plus a one-entry skid register. in_ready is a pure
// function of the state register, so it never depends on out_ready combinationally.
// Ports:
//   clk, rst (async, active-high), flush (sync discard of held entries)
//   in_valid/in_ready/in_instr/in_pc           fetch side
//   out_valid/out_ready                        consumer handshake
//   out_pc/out_rd/out_rs1/out_rs2/out_imm      decoded entry
//   out_func3/out_func7/out_fmt/out_illegal
// While no entry is valid, the data outputs read zero and out_pc reads PC_RESET.
module decode_stage
  import decode_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] PC_RESET = '0
)(
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_func3,
  output logic [6:0]      out_func7,
  output logic [2:0]      out_fmt,
  output logic            out_illegal
);

  skid_state_e         state_p1;
  skid_state_e         state_nxt;
  decoded_t            dec_p0;
  decoded_t            out_p1;
  decoded_t            skid_p1;
  logic [XLEN_MAX-1:0] pc_ext_p0;
  logic                acc;
  logic                pop;
  logic                vld_p1;
  logic                load_out_dec;
  logic                load_out_skid;
  logic                load_skid;
  logic                unused_hi_bits;

  // Stage 0: zero-extend pc and decode the incoming instruction
  always_comb begin
    pc_ext_p0             = '0;
    pc_ext_p0[XLEN-1:0]   = in_pc;
  end

  decode_comb u_decode_comb (
    .instr (in_instr),
    .pc    (pc_ext_p0),
    .dec   (dec_p0)
  );

  assign vld_p1   = (state_p1 != ST_EMPTY);
  assign in_ready = (state_p1 != ST_FULL);
  assign acc      = in_valid && in_ready;
  assign pop      = vld_p1 && out_ready;

  always_comb begin
    state_nxt     = state_p1;
    load_out_dec  = 1'b0;
    load_out_skid = 1'b0;
    load_skid     = 1'b0;
    if (flush) begin
      state_nxt = ST_EMPTY;
    end else begin
      unique case (state_p1)
        ST_EMPTY: begin
          if (acc) begin
            state_nxt    = ST_ONE;
            load_out_dec = 1'b1;
          end
        end
        ST_ONE: begin
          if (acc && !pop) begin
            state_nxt = ST_FULL;
            load_skid = 1'b1;
          end else if (acc && pop) begin
            load_out_dec = 1'b1;
          end else if (pop) begin
            state_nxt = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (pop) begin
            state_nxt     = ST_ONE;
            load_out_skid = 1'b1;
          end
        end
        default: state_nxt = ST_EMPTY;
      endcase
    end
  end

  // Stage 1: output and skid registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_p1 <= ST_EMPTY;
    end else begin
      state_p1 <= state_nxt;
    end
  end

  // Data registers carry no reset; the outputs are masked while state is EMPTY.
  always_ff @(posedge clk) begin
    if (load_out_dec) begin
      out_p1 <= dec_p0;
    end else if (load_out_skid) begin
      out_p1 <= skid_p1;
    end
    if (load_skid) begin
      skid_p1 <= dec_p0;
    end
  end

  always_comb begin
    out_valid   = vld_p1;
    out_pc      = PC_RESET;
    out_rd      = '0;
    out_rs1     = '0;
    out_rs2     = '0;
    out_imm     = '0;
    out_func3   = '0;
    out_func7   = '0;
    out_fmt     = '0;
    out_illegal = 1'b0;
    if (vld_p1) begin
      out_pc      = out_p1.pc[XLEN-1:0];
      out_rd      = out_p1.rd;
      out_rs1     = out_p1.rs1;
      out_rs2     = out_p1.rs2;
      out_imm     = out_p1.imm[XLEN-1:0];
      out_func3   = out_p1.func3;
      out_func7   = out_p1.func7;
      out_fmt     = out_p1.fmt;
      out_illegal = out_p1.illegal;
    end
  end

  // Bits above XLEN in the wide entry are intentionally dropped.
  assign unused_hi_bits = ^out_p1;

endmodule
